// File: rtl/qpsk_tx_pkg.sv
`default_nettype none
// ============================================================================
// Module      : qpsk_tx_pkg
// Description : Shared types and constants for the QPSK transmit sequencer.
//               tx_state_t        - frame sequencer state encoding
//               PREAMBLE_PATTERN  - byte repeated during the preamble field
//               DEFAULT_SYNC_WORD - default 16-bit sync field
// Revision    : 1.0 - initial release
// ============================================================================
package qpsk_tx_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_PREAMBLE = 3'd1,
        ST_SYNC     = 3'd2,
        ST_LEN      = 3'd3,
        ST_PAYLOAD  = 3'd4,
        ST_TAIL     = 3'd5
    } tx_state_t;

    localparam logic [7:0]  PREAMBLE_PATTERN  = 8'h55;
    localparam logic [15:0] DEFAULT_SYNC_WORD = 16'hD391;

endpackage
`default_nettype wire

// File: rtl/qpsk_tx_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module      : qpsk_tx_sequencer_if
// Description : Control, payload stream and modulator-side signals of the
//               QPSK transmit sequencer.
//               start/len/abort         - frame request and kill
//               s_data/s_valid/s_ready  - payload byte stream
//               bit_out/bit_en          - modulator bit_in / enable
//               busy/done/underrun      - status
//               modport master : frame source / modulator side (drives requests)
//               modport slave  : the sequencer
// Revision    : 1.0 - initial release
// ============================================================================
interface qpsk_tx_sequencer_if;

    logic       start;
    logic [7:0] len;
    logic       abort;
    logic [7:0] s_data;
    logic       s_valid;
    logic       s_ready;
    logic       bit_out;
    logic       bit_en;
    logic       busy;
    logic       done;
    logic       underrun;

    modport master (
        output start, len, abort, s_data, s_valid,
        input  s_ready, bit_out, bit_en, busy, done, underrun
    );

    modport slave (
        input  start, len, abort, s_data, s_valid,
        output s_ready, bit_out, bit_en, busy, done, underrun
    );

endinterface
`default_nettype wire

// File: rtl/qpsk_tx_sequencer_baud_tick_gen.sv
`default_nettype none
// ============================================================================
// Module      : baud_tick_gen
// Description : Bit-period counter. Counts 0..CLK_PER_BIT-1 while run is
//               high and raises tick on the last clock of each bit period.
//               clk   - clock
//               rst_n - asynchronous active-low reset
//               run   - count enable (sequencer not idle)
//               clear - restart the bit period at zero
//               tick  - last clock of the current bit period
// Revision    : 1.0 - initial release
// ============================================================================
module baud_tick_gen #(
    parameter int unsigned CLK_PER_BIT = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic run,
    input  logic clear,
    output logic tick
);

    localparam int unsigned          c_CNT_W = $clog2(CLK_PER_BIT);
    localparam logic [c_CNT_W-1:0]   c_LAST  = c_CNT_W'(CLK_PER_BIT - 1);

    logic [c_CNT_W-1:0] r_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (clear) begin
            r_count <= '0;
        end else if (run) begin
            r_count <= (r_count == c_LAST) ? '0 : r_count + 1'b1;
        end
    end

    // Gated by run so a counter left mid-period by an abort never ticks in idle.
    assign tick = run && (r_count == c_LAST);

endmodule
`default_nettype wire

// File: rtl/qpsk_tx_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : qpsk_tx_sequencer
// Description : Frame sequencer for the QPSK modulator. Emits preamble,
//               sync word, length byte, payload and zero tail bits, one bit
//               every CLK_PER_BIT clocks, MSB first.
//               clk   - clock
//               rst_n - asynchronous active-low reset
//               bus   - slave side of qpsk_tx_sequencer_if
// Revision    : 1.0 - initial release
// ============================================================================
module qpsk_tx_sequencer
    import qpsk_tx_pkg::*;
#(
    parameter int unsigned CLK_PER_BIT    = 16,
    parameter int unsigned PREAMBLE_BYTES = 4,
    parameter logic [15:0] SYNC_WORD      = DEFAULT_SYNC_WORD,
    parameter int unsigned TAIL_BITS      = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    qpsk_tx_sequencer_if.slave   bus
);

    localparam logic [15:0] c_PRE_LAST  = 16'(PREAMBLE_BYTES - 1);
    localparam logic [15:0] c_TAIL_LAST = 16'(TAIL_BITS - 1);

    tx_state_t   r_state,      w_state_nxt;
    logic [7:0]  r_shift,      w_shift_nxt;
    logic [2:0]  r_bit_idx,    w_bit_idx_nxt;
    logic [15:0] r_cnt,        w_cnt_nxt;
    logic [7:0]  r_len,        w_len_nxt;
    logic [7:0]  r_sent,       w_sent_nxt;
    logic [7:0]  r_fetched,    w_fetched_nxt;
    logic [7:0]  r_hold,       w_hold_nxt;
    logic        r_hold_valid, w_hold_valid_nxt;
    logic        r_done,       w_done_nxt;
    logic        r_underrun,   w_underrun_nxt;

    logic w_run;
    logic w_tick;
    logic w_start_accept;
    logic w_s_ready;
    logic w_xfer;

    assign w_run          = (r_state != ST_IDLE);
    assign w_start_accept = (r_state == ST_IDLE) && bus.start && !bus.abort;
    assign w_s_ready      = ((r_state == ST_LEN) || (r_state == ST_PAYLOAD)) &&
                            !r_hold_valid && (r_fetched < r_len);
    assign w_xfer         = w_s_ready && bus.s_valid;

    baud_tick_gen #(
        .CLK_PER_BIT (CLK_PER_BIT)
    ) u_baud (
        .clk   (clk),
        .rst_n (rst_n),
        .run   (w_run),
        .clear (w_start_accept),
        .tick  (w_tick)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_shift      <= 8'h00;
            r_bit_idx    <= 3'd0;
            r_cnt        <= 16'd0;
            r_len        <= 8'h00;
            r_sent       <= 8'h00;
            r_fetched    <= 8'h00;
            r_hold       <= 8'h00;
            r_hold_valid <= 1'b0;
            r_done       <= 1'b0;
            r_underrun   <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_shift      <= w_shift_nxt;
            r_bit_idx    <= w_bit_idx_nxt;
            r_cnt        <= w_cnt_nxt;
            r_len        <= w_len_nxt;
            r_sent       <= w_sent_nxt;
            r_fetched    <= w_fetched_nxt;
            r_hold       <= w_hold_nxt;
            r_hold_valid <= w_hold_valid_nxt;
            r_done       <= w_done_nxt;
            r_underrun   <= w_underrun_nxt;
        end
    end

    always_comb begin
        w_state_nxt      = r_state;
        w_shift_nxt      = r_shift;
        w_bit_idx_nxt    = r_bit_idx;
        w_cnt_nxt        = r_cnt;
        w_len_nxt        = r_len;
        w_sent_nxt       = r_sent;
        w_fetched_nxt    = r_fetched;
        w_hold_nxt       = r_hold;
        w_hold_valid_nxt = r_hold_valid;
        w_done_nxt       = 1'b0;
        w_underrun_nxt   = 1'b0;

        // A transfer only happens with the holding register empty, so it
        // never collides with a load from the holding register below.
        if (w_xfer) begin
            w_hold_nxt       = bus.s_data;
            w_hold_valid_nxt = 1'b1;
            w_fetched_nxt    = r_fetched + 8'd1;
        end

        if (r_state == ST_IDLE) begin
            if (w_start_accept) begin
                w_state_nxt      = ST_PREAMBLE;
                w_shift_nxt      = PREAMBLE_PATTERN;
                w_bit_idx_nxt    = 3'd0;
                w_cnt_nxt        = 16'd0;
                w_len_nxt        = bus.len;
                w_sent_nxt       = 8'h00;
                w_fetched_nxt    = 8'h00;
                w_hold_valid_nxt = 1'b0;
            end
        end else if (w_tick) begin
            if (r_state == ST_TAIL) begin
                // Tail length is counted in bits, not bytes.
                if (r_cnt == c_TAIL_LAST) begin
                    w_state_nxt = ST_IDLE;
                    w_cnt_nxt   = 16'd0;
                    w_done_nxt  = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt + 16'd1;
                end
            end else if (r_bit_idx != 3'd7) begin
                w_shift_nxt   = {r_shift[6:0], 1'b0};
                w_bit_idx_nxt = r_bit_idx + 3'd1;
            end else begin
                // Byte boundary: pick the next field byte.
                w_bit_idx_nxt = 3'd0;
                case (r_state)
                    ST_PREAMBLE: begin
                        if (r_cnt == c_PRE_LAST) begin
                            w_state_nxt = ST_SYNC;
                            w_shift_nxt = SYNC_WORD[15:8];
                            w_cnt_nxt   = 16'd0;
                        end else begin
                            w_shift_nxt = PREAMBLE_PATTERN;
                            w_cnt_nxt   = r_cnt + 16'd1;
                        end
                    end
                    ST_SYNC: begin
                        if (r_cnt == 16'd0) begin
                            w_shift_nxt = SYNC_WORD[7:0];
                            w_cnt_nxt   = 16'd1;
                        end else begin
                            w_state_nxt = ST_LEN;
                            w_shift_nxt = r_len;
                            w_cnt_nxt   = 16'd0;
                        end
                    end
                    ST_LEN, ST_PAYLOAD: begin
                        if ((r_state == ST_LEN && r_len == 8'h00) ||
                            (r_state == ST_PAYLOAD && r_sent == r_len - 8'd1)) begin
                            w_state_nxt = ST_TAIL;
                            w_shift_nxt = 8'h00;
                            w_cnt_nxt   = 16'd0;
                        end else begin
                            w_state_nxt = ST_PAYLOAD;
                            w_sent_nxt  = (r_state == ST_LEN) ? 8'h00 : r_sent + 8'd1;
                            // Bit timing never stretches: a missing byte goes
                            // out as zeros and still counts as sent.
                            if (r_hold_valid) begin
                                w_shift_nxt      = r_hold;
                                w_hold_valid_nxt = 1'b0;
                            end else begin
                                w_shift_nxt    = 8'h00;
                                w_underrun_nxt = 1'b1;
                            end
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end

        if (bus.abort && (r_state != ST_IDLE)) begin
            w_state_nxt      = ST_IDLE;
            w_shift_nxt      = 8'h00;
            w_bit_idx_nxt    = 3'd0;
            w_cnt_nxt        = 16'd0;
            w_hold_valid_nxt = 1'b0;
            w_done_nxt       = 1'b0;
            w_underrun_nxt   = 1'b0;
        end
    end

    assign bus.bit_out  = r_shift[7];
    assign bus.bit_en   = w_tick;
    assign bus.busy     = w_run;
    assign bus.done     = r_done;
    assign bus.underrun = r_underrun;
    assign bus.s_ready  = w_s_ready;

endmodule
`default_nettype wire

// File: tb/tb_qpsk_tx_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_qpsk_tx_sequencer
// Description : Directed bench for qpsk_tx_sequencer with default parameters
//               (16 clocks/bit, 4 preamble bytes, sync 0xD391, 4 tail bits).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_qpsk_tx_sequencer;

    localparam int TAIL = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    qpsk_tx_sequencer_if bus ();

    qpsk_tx_sequencer #(
        .CLK_PER_BIT    (16),
        .PREAMBLE_BYTES (4),
        .SYNC_WORD      (16'hD391),
        .TAIL_BITS      (4)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int         n_vec = 0;
    int         n_err = 0;
    int         cyc = 0;
    int         t0 = 0;
    int         t1 = 0;
    int         late_at = -1;
    logic [7:0] late_byte = 8'h00;
    logic [7:0] feed_q[$];
    logic [7:0] exp_q[$];
    bit         bits[$];
    int         n_ben = 0;
    int         n_unr = 0;
    int         n_done = 0;
    int         n_rdy = 0;
    int         first_ben = -1;
    int         unr_cyc = -1;
    bit         feed_xfer;
    bit         ok;

    always @(posedge clk) cyc <= cyc + 1;

    // Observation on the falling edge, away from the active edge.
    always @(negedge clk) begin
        if (bus.bit_en) begin
            if (first_ben < 0) first_ben = cyc;
            bits.push_back(bus.bit_out);
            n_ben++;
        end
        if (bus.underrun) begin
            n_unr++;
            unr_cyc = cyc;
        end
        if (bus.done)    n_done++;
        if (bus.s_ready) n_rdy++;
    end

    // Payload source: presents the head of feed_q whenever it is non-empty.
    initial begin
        bus.s_valid = 1'b0;
        bus.s_data  = 8'h00;
        forever begin
            @(negedge clk);
            feed_xfer = bus.s_valid && bus.s_ready;
            @(posedge clk);
            #1;
            if (feed_xfer && feed_q.size() > 0) void'(feed_q.pop_front());
            if (feed_q.size() > 0) begin
                bus.s_valid = 1'b1;
                bus.s_data  = feed_q[0];
            end else begin
                bus.s_valid = 1'b0;
                bus.s_data  = 8'h00;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic clr_mon();
        bits.delete();
        n_ben = 0; n_unr = 0; n_done = 0; n_rdy = 0;
        first_ben = -1; unr_cyc = -1;
    endtask

    task automatic start_frame(input logic [7:0] l);
        bus.start = 1'b1;
        bus.len   = l;
        t0        = cyc;
        cycle();
        bus.start = 1'b0;
    endtask

    task automatic wait_rel(input int rel);
        while (cyc - t0 < rel) cycle();
    endtask

    task automatic wait_done(input int budget, output bit seen);
        seen = 1'b0;
        for (int k = 0; k < budget; k++) begin
            cycle();
            if (late_at >= 0 && (cyc - t0) == late_at) feed_q.push_back(late_byte);
            if (bus.done) begin
                seen = 1'b1;
                break;
            end
        end
    endtask

    task automatic check_frame(input string tag);
        logic [7:0] b;
        logic [3:0] tl;
        chk({tag, "_nbits"}, bits.size(), 8 * exp_q.size() + TAIL);
        for (int i = 0; i < exp_q.size(); i++) begin
            b = 8'h00;
            for (int j = 0; j < 8; j++)
                b = {b[6:0], (8 * i + j < bits.size()) ? bits[8 * i + j] : 1'b1};
            chk($sformatf("%s_byte%0d", tag, i), b, exp_q[i]);
        end
        tl = 4'h0;
        for (int j = 0; j < TAIL; j++)
            tl = {tl[2:0], (8 * exp_q.size() + j < bits.size()) ? bits[8 * exp_q.size() + j] : 1'b1};
        chk({tag, "_tail"}, tl, 4'h0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: bench did not complete in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus.start = 1'b0;
        bus.len   = 8'h00;
        bus.abort = 1'b0;

        // Reset state
        repeat (3) cycle();
        chk("rst_outputs", {bus.bit_out, bus.bit_en, bus.s_ready, bus.busy, bus.done, bus.underrun}, 6'b0);
        rst_n = 1'b1;
        cycle();
        chk("idle_outputs", {bus.bit_out, bus.bit_en, bus.s_ready, bus.busy, bus.done, bus.underrun}, 6'b0);

        // len=2, payload presented early
        clr_mon();
        feed_q = {8'hA5, 8'h3C};
        cycle();
        start_frame(8'd2);
        chk("l2_busy_t1", bus.busy, 1'b1);
        chk("l2_bit_t1", bus.bit_out, 1'b0);
        wait_done(1400, ok);
        chk("l2_done_seen", ok, 1'b1);
        chk("l2_done_cyc", cyc - t0, 1217);
        chk("l2_busy_end", bus.busy, 1'b0);
        chk("l2_first_ben", first_ben - t0, 16);
        chk("l2_nben", n_ben, 76);
        chk("l2_nunr", n_unr, 0);
        exp_q = {8'h55, 8'h55, 8'h55, 8'h55, 8'hD3, 8'h91, 8'h02, 8'hA5, 8'h3C};
        check_frame("l2");

        // len=0
        cycle();
        clr_mon();
        start_frame(8'd0);
        wait_done(1100, ok);
        chk("l0_done_seen", ok, 1'b1);
        chk("l0_done_cyc", cyc - t0, 961);
        chk("l0_nben", n_ben, 60);
        chk("l0_nrdy", n_rdy, 0);
        exp_q = {8'h55, 8'h55, 8'h55, 8'h55, 8'hD3, 8'h91, 8'h00};
        check_frame("l0");

        // len=3 with the second payload byte missing
        cycle();
        clr_mon();
        feed_q    = {8'h11};
        late_at   = 1030;
        late_byte = 8'h33;
        start_frame(8'd3);
        wait_done(1500, ok);
        late_at = -1;
        chk("ur_done_seen", ok, 1'b1);
        chk("ur_done_cyc", cyc - t0, 1345);
        chk("ur_nben", n_ben, 84);
        chk("ur_nunr", n_unr, 1);
        chk("ur_unr_cyc", unr_cyc - t0, 1025);
        exp_q = {8'h55, 8'h55, 8'h55, 8'h55, 8'hD3, 8'h91, 8'h03, 8'h11, 8'h00, 8'h33};
        check_frame("ur");

        // abort during SYNC, then restart two cycles later
        cycle();
        clr_mon();
        start_frame(8'd0);
        wait_rel(516);
        chk("ab_bit_pre", bus.bit_out, 1'b1);
        chk("ab_busy_pre", bus.busy, 1'b1);
        bus.abort = 1'b1;
        cycle();
        bus.abort = 1'b0;
        chk("ab_bit_post", bus.bit_out, 1'b0);
        chk("ab_busy_post", bus.busy, 1'b0);
        chk("ab_ben_post", bus.bit_en, 1'b0);
        cycle();
        chk("ab_no_done", n_done, 0);
        clr_mon();
        start_frame(8'd0);
        wait_done(1100, ok);
        chk("ab_re_done_cyc", cyc - t0, 961);
        chk("ab_re_nben", n_ben, 60);
        exp_q = {8'h55, 8'h55, 8'h55, 8'h55, 8'hD3, 8'h91, 8'h00};
        check_frame("ab_re");

        // start and abort together from idle
        cycle();
        clr_mon();
        bus.start = 1'b1;
        bus.abort = 1'b1;
        bus.len   = 8'd0;
        cycle();
        bus.start = 1'b0;
        bus.abort = 1'b0;
        chk("sa_busy", bus.busy, 1'b0);
        repeat (20) cycle();
        chk("sa_nben", n_ben, 0);

        // start while busy is ignored; back-to-back start in the done cycle
        clr_mon();
        feed_q = {8'h81};
        start_frame(8'd0);
        wait_rel(200);
        bus.start = 1'b1;
        bus.len   = 8'd5;
        cycle();
        bus.start = 1'b0;
        wait_done(1100, ok);
        chk("bb_a_done_cyc", cyc - t0, 961);
        chk("bb_a_nben", n_ben, 60);
        exp_q = {8'h55, 8'h55, 8'h55, 8'h55, 8'hD3, 8'h91, 8'h00};
        check_frame("bb_a");
        clr_mon();
        start_frame(8'd1);
        chk("bb_b_busy", bus.busy, 1'b1);
        wait_done(1200, ok);
        chk("bb_b_done_cyc", cyc - t0, 1089);
        chk("bb_b_nben", n_ben, 68);
        exp_q = {8'h55, 8'h55, 8'h55, 8'h55, 8'hD3, 8'h91, 8'h01, 8'h81};
        check_frame("bb_b");

        // asynchronous reset mid-payload
        cycle();
        clr_mon();
        feed_q = {8'hA5, 8'h3C};
        start_frame(8'd2);
        wait_rel(905);
        chk("rs_busy_pre", bus.busy, 1'b1);
        chk("rs_bit_pre", bus.bit_out, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        chk("rs_outputs", {bus.bit_out, bus.bit_en, bus.s_ready, bus.busy, bus.done, bus.underrun}, 6'b0);
        repeat (3) cycle();
        rst_n = 1'b1;
        feed_q.delete();
        clr_mon();
        repeat (40) cycle();
        chk("rs_idle_nben", n_ben, 0);
        chk("rs_idle_busy", bus.busy, 1'b0);
        chk("rs_idle_rdy", n_rdy, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
